// File: rtl/disp_pkg.sv
// Shared types and default sizing for the display BCD conversion path.
package disp_pkg;

  localparam int unsigned MAG_W  = 15;
  localparam int unsigned DIGITS = 5;
  localparam int unsigned ITER_W = $clog2(MAG_W);

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } conv_state_t;

endpackage

// File: rtl/bcd_add3.sv
// Per-digit double-dabble correction: add 3 to any digit of 5 or more before the shift.
module bcd_add3
  import disp_pkg::*;
(
  input  bcd_digit_t i_digit,
  output bcd_digit_t o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/disp_bcd_conv.sv
// Sequential sign-magnitude to BCD converter (shift-and-add-3) with leading-zero blanking.
module disp_bcd_conv
  import disp_pkg::*;
#(
  parameter int unsigned MAG_W  = disp_pkg::MAG_W,
  parameter int unsigned DIGITS = disp_pkg::DIGITS
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [MAG_W:0]        value_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  sign_out,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank_mask
);

  localparam int unsigned CntW = (MAG_W > 1) ? $clog2(MAG_W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MAG_W - 1);

  conv_state_t         r_state, w_state_d;
  logic [MAG_W-1:0]    r_bin, w_bin_d;
  logic [4*DIGITS-1:0] r_bcd, w_bcd_d;
  logic [4*DIGITS-1:0] w_bcd_adj;
  logic [CntW-1:0]     r_cnt, w_cnt_d;
  logic                r_sign_pend, w_sign_pend_d;
  logic                r_busy, w_busy_d;
  logic                r_done, w_done_d;
  logic                r_sign_out, w_sign_out_d;
  logic [4*DIGITS-1:0] r_bcd_out, w_bcd_out_d;
  logic [DIGITS-1:0]   r_mask, w_mask_d;
  logic [DIGITS-1:0]   w_mask;
  logic                w_lead;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_digit (r_bcd[4*g +: 4]),
      .o_digit (w_bcd_adj[4*g +: 4])
    );
  end

  // A digit is blanked only while it and every digit above it are zero.
  always_comb begin
    w_lead = 1'b1;
    w_mask = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      w_lead    = w_lead & (r_bcd[4*i +: 4] == 4'd0);
      w_mask[i] = w_lead;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_bin_d       = r_bin;
    w_bcd_d       = r_bcd;
    w_cnt_d       = r_cnt;
    w_sign_pend_d = r_sign_pend;
    w_busy_d      = r_busy;
    w_done_d      = 1'b0;
    w_sign_out_d  = r_sign_out;
    w_bcd_out_d   = r_bcd_out;
    w_mask_d      = r_mask;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_bin_d       = value_in[MAG_W-1:0];
          w_sign_pend_d = value_in[MAG_W];
          w_bcd_d       = '0;
          w_cnt_d       = '0;
          w_busy_d      = 1'b1;
          w_state_d     = SHIFT;
        end
      end
      SHIFT: begin
        w_bcd_d = {w_bcd_adj[4*DIGITS-2:0], r_bin[MAG_W-1]};
        w_bin_d = {r_bin[MAG_W-2:0], 1'b0};
        w_cnt_d = r_cnt + 1'b1;
        if (r_cnt == CntLast) begin
          w_state_d = FINISH;
        end
      end
      FINISH: begin
        w_bcd_out_d  = r_bcd;
        w_mask_d     = w_mask;
        // Negative zero is shown as plain zero.
        w_sign_out_d = r_sign_pend & (r_bcd != '0);
        w_done_d     = 1'b1;
        w_busy_d     = 1'b0;
        w_state_d    = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state     <= IDLE;
      r_bin       <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_sign_pend <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sign_out  <= 1'b0;
      r_bcd_out   <= '0;
      r_mask      <= '0;
    end else begin
      r_state     <= w_state_d;
      r_bin       <= w_bin_d;
      r_bcd       <= w_bcd_d;
      r_cnt       <= w_cnt_d;
      r_sign_pend <= w_sign_pend_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
      r_sign_out  <= w_sign_out_d;
      r_bcd_out   <= w_bcd_out_d;
      r_mask      <= w_mask_d;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign sign_out   = r_sign_out;
  assign bcd_out    = r_bcd_out;
  assign blank_mask = r_mask;

endmodule

// File: tb/tb_disp_bcd_conv.sv
// Self-checking bench: decimal reference model plus directed literal cases for disp_bcd_conv.
module tb_disp_bcd_conv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value_in = '0;
  logic        start = 1'b0;
  logic        busy, done, sign_out;
  logic [19:0] bcd_out;
  logic [4:0]  blank_mask;

  int tests = 0;
  int fails = 0;

  disp_bcd_conv dut (
    .clk        (clk),
    .RST        (rst),
    .value_in   (value_in),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .sign_out   (sign_out),
    .bcd_out    (bcd_out),
    .blank_mask (blank_mask)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] to_bcd(input int unsigned mag);
    logic [19:0] r;
    int unsigned m;
    r = '0;
    m = mag;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] mask_of(input int unsigned mag);
    logic [4:0] r;
    int unsigned p;
    r = '0;
    p = 10;
    for (int i = 1; i < 5; i++) begin
      r[i] = (mag < p);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails < 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an accepted request yields its decimal result 16 edges later.
  logic        m_busy = 1'b0, m_done = 1'b0, m_sign = 1'b0;
  logic [19:0] m_bcd = '0;
  logic [4:0]  m_mask = '0;
  logic [15:0] m_val = '0;
  int          m_left = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_sign <= 1'b0;
      m_bcd <= '0; m_mask <= '0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_bcd  <= to_bcd(int'(m_val[14:0]));
          m_mask <= mask_of(int'(m_val[14:0]));
          m_sign <= m_val[15] && (m_val[14:0] != 0);
        end
        m_left <= m_left - 1;
      end else if (start) begin
        m_busy <= 1'b1;
        m_left <= 16;
        m_val  <= value_in;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("sign", 32'(sign_out), 32'(m_sign));
    chk("bcd", 32'(bcd_out), 32'(m_bcd));
    chk("mask", 32'(blank_mask), 32'(m_mask));
  end

  // Waits for done and returns the number of cycles after the accepting edge.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse(input logic [15:0] v);
    value_in = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic directed(input string name, input logic [15:0] v, input logic [19:0] eb,
                          input logic [4:0] em, input logic es);
    int lat;
    pulse(v);
    wait_done(lat);
    chk({name, "_lat"}, 32'(lat), 32'd16);
    chk({name, "_bcd"}, 32'(bcd_out), 32'(eb));
    chk({name, "_mask"}, 32'(blank_mask), 32'(em));
    chk({name, "_sign"}, 32'(sign_out), 32'(es));
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int seen;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    directed("d34", 16'd34, 20'h00034, 5'b11100, 1'b0);
    directed("dmax", 16'h7FFF, 20'h32767, 5'b00000, 1'b0);
    directed("d1998", {1'b1, 15'd1998}, 20'h01998, 5'b10000, 1'b1);
    directed("dnegz", 16'h8000, 20'h00000, 5'b11110, 1'b0);

    // Start while busy is dropped; start during done is taken.
    pulse(16'd34);
    repeat (4) @(negedge clk);
    pulse(16'd99);
    value_in = 16'd7;
    wait_done(lat);
    chk("busy_ign_bcd", 32'(bcd_out), 32'h34);
    value_in = 16'd99;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    value_in = 16'd5;
    wait_done(lat);
    chk("b2b_lat", 32'(lat + 1), 32'd17);
    chk("b2b_bcd", 32'(bcd_out), 32'h99);
    @(negedge clk);

    // Asynchronous reset in the middle of a conversion.
    pulse(16'd1234);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_bcd", 32'(bcd_out), 32'd0);
    chk("arst_sign", 32'(sign_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (24) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("arst_no_done", 32'(seen), 32'd0);
    directed("after_rst", 16'd1234, 20'h01234, 5'b10000, 1'b0);

    // Reset and start on the same edge: reset wins.
    value_in = 16'd55;
    start = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", 32'(busy), 32'd0);

    // Random traffic with spurious starts and changing inputs.
    for (int n = 0; n < 1500; n++) begin
      value_in = 16'($urandom);
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) value_in[14:0] = 15'($urandom_range(0, 12));
      @(negedge clk);
    end
    start = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
